// File: rtl/adder_pkg.sv
// Shared defaults, stage-record layout and stage-count helper for the segmented pipelined adder.
package adder_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SEGMENT = 8;

  typedef struct packed {
    logic valid;
    logic carry;
    logic carryMsb;
  } stageCtl_t;

  // Default-width view of one pipeline stage; the adder declares the same layout at its own WIDTH.
  typedef struct packed {
    stageCtl_t              ctl;
    logic [DEF_WIDTH-1:0]   opA;
    logic [DEF_WIDTH-1:0]   opB;
    logic [DEF_WIDTH-1:0]   sum;
  } stageRec_t;

  function automatic int stageCount(input int width, input int segment);
    return (segment < 1) ? 1 : width / segment;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEGMENT-bit ripple adder; zero latency, no flow control.
// Also reports the carry into its top bit so the last stage can derive signed overflow.
module adder_segment #(
  parameter int SEGMENT = 8
) (
  input  logic [SEGMENT-1:0] a,
  input  logic [SEGMENT-1:0] b,
  input  logic               carryIn,
  output logic [SEGMENT-1:0] sum,
  output logic               carryOut,
  output logic               carryMsb
);

  logic c;

  always_comb begin
    c        = carryIn;
    carryMsb = carryIn;
    sum      = '0;
    for (int i = 0; i < SEGMENT; i++) begin
      if (i == SEGMENT - 1) carryMsb = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    carryOut = c;
  end

endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract split into WIDTH/SEGMENT registered ripple stages; result leaves the last stage register.
// Each stage holds when full and downstream holds; empty stages fill under a stall; in_ready is stage 0's advance.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SEGMENT = DEF_SEGMENT
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CarryIn,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut,
  output logic             Overflow
);

  localparam int STAGES = stageCount(WIDTH, SEGMENT);

  if (SEGMENT < 1) begin : g_badSegment
    $error("pipelined_adder: SEGMENT must be at least 1");
  end else if (WIDTH % SEGMENT != 0) begin : g_badWidth
    $error("pipelined_adder: WIDTH must be a multiple of SEGMENT");
  end

  typedef struct packed {
    stageCtl_t        ctl;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] sum;
  } stage_t;

  stage_t              pipe [STAGES];
  stage_t              src  [STAGES];
  stage_t              nxt  [STAGES];
  logic [SEGMENT-1:0]  segSum   [STAGES];
  logic                segCarry [STAGES];
  logic                segMsb   [STAGES];
  logic [STAGES-1:0]   adv;

  // Subtraction is folded in at entry: B is inverted and the carry-in becomes CarryIn^Sub.
  always_comb begin
    src[0]              = '0;
    src[0].ctl.valid    = in_valid;
    src[0].ctl.carry    = CarryIn ^ Sub;
    src[0].opA          = A;
    src[0].opB          = Sub ? ~B : B;
    for (int k = 1; k < STAGES; k++) begin
      src[k] = pipe[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    adder_segment #(.SEGMENT(SEGMENT)) u_seg (
      .a        (src[k].opA[k*SEGMENT +: SEGMENT]),
      .b        (src[k].opB[k*SEGMENT +: SEGMENT]),
      .carryIn  (src[k].ctl.carry),
      .sum      (segSum[k]),
      .carryOut (segCarry[k]),
      .carryMsb (segMsb[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nxt[k]                           = src[k];
      nxt[k].ctl.carry                 = segCarry[k];
      nxt[k].ctl.carryMsb              = segMsb[k];
      nxt[k].sum[k*SEGMENT +: SEGMENT] = segSum[k];
    end
  end

  always_comb begin
    adv           = '0;
    adv[STAGES-1] = !pipe[STAGES-1].ctl.valid || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !pipe[k].ctl.valid || adv[k+1];
    end
  end

  // Data registers only load with a valid operation, so bubbles never disturb Sum.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int k = 0; k < STAGES; k++) begin
        pipe[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          if (src[k].ctl.valid) pipe[k]           <= nxt[k];
          else                  pipe[k].ctl.valid <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = pipe[STAGES-1].ctl.valid;
  assign Sum       = pipe[STAGES-1].sum;
  assign CarryOut  = pipe[STAGES-1].ctl.carry;
  assign Overflow  = pipe[STAGES-1].ctl.carry ^ pipe[STAGES-1].ctl.carryMsb;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: default 32/8 instance and a 16/4 instance.
module tb_pipelined_adder;

  localparam int STG32 = 4;
  localparam int STG16 = 4;

  typedef struct {
    logic [31:0] sum;
    logic        co;
    logic        of;
    int          cyc;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
    logic [31:0] sum;
    logic        co;
    logic        of;
  } vec_t;

  logic clock;
  logic clear_n;

  logic        v32, r32, ci32, sub32, ov32, ordy32, co32, of32;
  logic [31:0] a32, b32, sum32;
  logic        v16, r16, ci16, sub16, ov16, ordy16, co16, of16;
  logic [15:0] a16, b16, sum16;

  int nCmp = 0;
  int nBad = 0;
  int cyc = 0;
  int push32 = 0;
  int pop32 = 0;
  int stall32 = -1;
  int stall16 = -1;
  bit done16 = 0;
  res_t exp32[$];
  res_t exp16[$];
  res_t e32, e16;
  vec_t tbl[10];

  pipelined_adder dut32 (
    .clock(clock), .clear_n(clear_n),
    .in_valid(v32), .in_ready(r32),
    .A(a32), .B(b32), .CarryIn(ci32), .Sub(sub32),
    .out_valid(ov32), .out_ready(ordy32),
    .Sum(sum32), .CarryOut(co32), .Overflow(of32)
  );

  pipelined_adder #(.WIDTH(16), .SEGMENT(4)) dut16 (
    .clock(clock), .clear_n(clear_n),
    .in_valid(v16), .in_ready(r16),
    .A(a16), .B(b16), .CarryIn(ci16), .Sub(sub16),
    .out_valid(ov16), .out_ready(ordy16),
    .Sum(sum16), .CarryOut(co16), .Overflow(of16)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nCmp++;
    if (act !== req) begin
      nBad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference: full-width add, overflow from operand/result sign agreement.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sub);
    res_t        r;
    logic [32:0] full;
    logic [31:0] mask, am, be;
    mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am    = a & mask;
    be    = (sub ? ~b : b) & mask;
    full  = {1'b0, am} + {1'b0, be} + {32'd0, ci ^ sub};
    r.sum = full[31:0] & mask;
    r.co  = full[w];
    r.of  = (am[w-1] == be[w-1]) && (r.sum[w-1] != am[w-1]);
    r.cyc = 0;
    return r;
  endfunction

  always @(negedge clock) begin
    if (clear_n) begin
      if (ov32 && !ordy32) stall32 = cyc;
      if (ov32 && ordy32) begin
        if (exp32.size() == 0) begin
          nCmp++; nBad++;
          $display("FAIL out32_unexpected: got sum %0h, required no output", sum32);
        end else begin
          e32 = exp32.pop_front();
          pop32++;
          chk("sum32", {32'd0, sum32}, {32'd0, e32.sum});
          chk("carry32", {63'd0, co32}, {63'd0, e32.co});
          chk("ovf32", {63'd0, of32}, {63'd0, e32.of});
          if (stall32 > e32.cyc) chk("lat32_min", {63'd0, (cyc - e32.cyc) >= STG32}, 64'd1);
          else                   chk("lat32", 64'(cyc - e32.cyc), 64'(STG32));
        end
      end
      if (ov16 && !ordy16) stall16 = cyc;
      if (ov16 && ordy16) begin
        if (exp16.size() == 0) begin
          nCmp++; nBad++;
          $display("FAIL out16_unexpected: got sum %0h, required no output", sum16);
        end else begin
          e16 = exp16.pop_front();
          chk("sum16", {48'd0, sum16}, {32'd0, e16.sum});
          chk("carry16", {63'd0, co16}, {63'd0, e16.co});
          chk("ovf16", {63'd0, of16}, {63'd0, e16.of});
          if (stall16 > e16.cyc) chk("lat16_min", {63'd0, (cyc - e16.cyc) >= STG16}, 64'd1);
          else                   chk("lat16", 64'(cyc - e16.cyc), 64'(STG16));
        end
      end
    end
  end

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input logic sub, input res_t e);
    int   t;
    res_t q;
    t = 0;
    q = e;
    v32 = 1'b1; a32 = a; b32 = b; ci32 = ci; sub32 = sub;
    @(negedge clock);
    while (!r32 && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!r32) begin
      nCmp++; nBad++;
      $display("FAIL accept32_timeout: got in_ready 0, required 1 within 200 cycles");
    end else begin
      q.cyc = cyc;
      exp32.push_back(q);
      push32++;
    end
    @(posedge clock); #1;
    v32 = 1'b0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic sub);
    int   t;
    res_t q;
    t = 0;
    q = model(16, {16'd0, a}, {16'd0, b}, ci, sub);
    v16 = 1'b1; a16 = a; b16 = b; ci16 = ci; sub16 = sub;
    @(negedge clock);
    while (!r16 && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!r16) begin
      nCmp++; nBad++;
      $display("FAIL accept16_timeout: got in_ready 0, required 1 within 200 cycles");
    end else begin
      q.cyc = cyc;
      exp16.push_back(q);
    end
    @(posedge clock); #1;
    v16 = 1'b0;
  endtask

  task automatic drain32();
    int t;
    t = 0;
    while (exp32.size() != 0 && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk("drain32_left", 64'(exp32.size()), 64'd0);
    @(posedge clock); #1;
  endtask

  task automatic drain16();
    int t;
    t = 0;
    while (exp16.size() != 0 && t < 300) begin
      @(negedge clock);
      t++;
    end
    chk("drain16_left", 64'(exp16.size()), 64'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rc, rs;
    logic [34:0] held;
    bit          sawFull;
    int          base;

    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[3] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    tbl[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
    tbl[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[6] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[8] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0};
    tbl[9] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0};

    clear_n = 1'b0;
    v32 = 1'b0; a32 = '0; b32 = '0; ci32 = 1'b0; sub32 = 1'b0; ordy32 = 1'b1;
    v16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0; sub16 = 1'b0; ordy16 = 1'b1;

    #12;
    chk("rst_out_valid32", {63'd0, ov32}, 64'd0);
    chk("rst_in_ready32", {63'd0, r32}, 64'd1);
    chk("rst_result32", {29'd0, sum32, co32, of32}, 64'd0);
    chk("rst_out_valid16", {63'd0, ov16}, 64'd0);
    chk("rst_in_ready16", {63'd0, r16}, 64'd1);
    #1 clear_n = 1'b1;
    @(negedge clock);
    chk("post_rst_in_ready32", {63'd0, r32}, 64'd1);
    @(posedge clock); #1;

    // Directed vectors, one at a time so each latency is unstalled.
    for (int i = 0; i < 10; i++) begin
      res_t e;
      e.sum = tbl[i].sum; e.co = tbl[i].co; e.of = tbl[i].of; e.cyc = 0;
      send32(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sub, e);
      drain32();
    end

    // Eight back-to-back ops; consumer stalls for 6 cycles after two results.
    base = pop32;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
          send32(ra, rb, rc, rs, model(32, ra, rb, rc, rs));
        end
      end
      begin
        int t;
        t = 0;
        sawFull = 1'b0;
        held = '0;
        while (pop32 < base + 2 && t < 100) begin
          @(negedge clock);
          t++;
        end
        @(posedge clock); #1;
        ordy32 = 1'b0;
        for (int j = 0; j < 6; j++) begin
          @(negedge clock);
          if (j == 0) held = {ov32, sum32, co32, of32};
          else chk("stall_stable32", {29'd0, ov32, sum32, co32, of32}, {29'd0, held});
          if (!r32) begin
            sawFull = 1'b1;
            chk("held_count32", 64'(push32 - pop32), 64'd4);
          end
        end
        chk("in_ready_fell32", {63'd0, sawFull}, 64'd1);
        @(posedge clock); #1;
        ordy32 = 1'b1;
        @(negedge clock);
        chk("full_pass_through32", {63'd0, r32}, 64'd1);
      end
    join
    drain32();
    chk("all_eight_out32", 64'(pop32 - base), 64'd8);

    // Reset with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      send32(32'd100 + 32'(i), 32'd3, 1'b0, 1'b0, model(32, 32'd100 + 32'(i), 32'd3, 1'b0, 1'b0));
    end
    @(posedge clock); #1;
    chk("pre_reset_out_valid32", {63'd0, ov32}, 64'd1);
    clear_n = 1'b0;
    exp32.delete();
    #1;
    chk("reset_out_valid32", {63'd0, ov32}, 64'd0);
    chk("reset_in_ready32", {63'd0, r32}, 64'd1);
    chk("reset_sum32", {32'd0, sum32}, 64'd0);
    @(negedge clock); #2;
    clear_n = 1'b1;
    @(posedge clock); #1;
    send32(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, model(32, 32'h10, 32'h20, 1'b1, 1'b0));
    drain32();

    // 16/4 instance: random ops against the model with random consumer stalls.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clock); #1;
          end
          send16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        done16 = 1'b1;
      end
      begin
        while (!done16) begin
          @(posedge clock); #1;
          ordy16 = ($urandom_range(0, 3) != 0);
        end
        ordy16 = 1'b1;
      end
    join
    drain16();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
